// File: rtl/text_line_renderer_pkg.sv
// Shared types for the text line renderer.
// The global font/screen defines are guarded so that the shared include can
// also define them without a clash. The package holds the field types and the
// length of the RENDER guard window.
`ifndef TEXT_LINE_GLOBAL_DEFINES
`define TEXT_LINE_GLOBAL_DEFINES
`define CHAR_BITES   8
`define X_BITES      9
`define Y_BITES      8
`define SQUARE_BITES 4
`define FONT_WIDTH   5
`define CHAR_SPACE   8'h20
`define CHAR_NUL     8'h00
`endif

package text_line_renderer_pkg;
    typedef logic [`CHAR_BITES-1:0]   char_t;
    typedef logic [`X_BITES-1:0]      x_t;
    typedef logic [`Y_BITES-1:0]      y_t;
    typedef logic [`SQUARE_BITES-1:0] sz_t;

    // RENDER ignores char_finished for this many cycles after entry, so a
    // stale finish flag from the previous glyph cannot end the new one.
    localparam int GUARD_CYCLES = 2;
endpackage

// File: rtl/text_line_renderer_if.sv
// Bundle between the page layer, the text buffer, the character renderer and
// the line renderer.
//   slave  : the line renderer's view (takes start/geometry, drives buffer
//            address and glyph requests, reports busy/done).
//   master : the surrounding system's view (the reverse directions).
interface text_line_renderer_if #(
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 6
);
    import text_line_renderer_pkg::*;

    logic              start;
    x_t                origin_x;
    y_t                origin_y;
    sz_t               size;
    logic [LEN_W-1:0]  length;
    logic [ADDR_W-1:0] buf_addr;
    char_t             buf_data;
    char_t             char_out;
    x_t                char_origin_x;
    y_t                char_origin_y;
    logic              char_enable;
    logic              char_finished;
    logic              busy;
    logic              done;

    modport slave (
        input  start, origin_x, origin_y, size, length, buf_data, char_finished,
        output buf_addr, char_out, char_origin_x, char_origin_y, char_enable,
               busy, done
    );

    modport master (
        output start, origin_x, origin_y, size, length, buf_data, char_finished,
        input  buf_addr, char_out, char_origin_x, char_origin_y, char_enable,
               busy, done
    );
endinterface

// File: rtl/text_line_renderer_glyph_advance_calc.sv
// Combinational glyph pitch and clip test.
//   sz_i     : latched pixel scale
//   cur_x_i  : origin of the glyph under consideration
//   next_x_o : origin of the following glyph (cur_x + advance)
//   clip_o   : glyph would extend past SCREEN_WIDTH
module text_line_renderer_glyph_advance_calc
    import text_line_renderer_pkg::*;
#(
    parameter int CHAR_GAP     = 1,
    parameter int SCREEN_WIDTH = 320
) (
    input  sz_t  sz_i,
    input  x_t   cur_x_i,
    output x_t   next_x_o,
    output logic clip_o
);
    localparam x_t PITCH = x_t'(`FONT_WIDTH + CHAR_GAP);

    x_t               advance;
    logic [`X_BITES:0] sum;

    // Advance is truncated to the X width; the sum keeps one extra bit so a
    // wrap past the top of the X range still reads as off-screen.
    assign advance  = x_t'(sz_i) * PITCH;
    assign sum      = {1'b0, cur_x_i} + {1'b0, advance};
    assign clip_o   = sum > (`X_BITES+1)'(SCREEN_WIDTH);
    assign next_x_o = sum[`X_BITES-1:0];
endmodule

// File: rtl/text_line_renderer.sv
// Text line renderer: walks a text buffer and issues one glyph request at a
// time to the character renderer.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : start/origin/size/length from the page layer, buffer read
//                  port (1-cycle latency), glyph request/finish handshake,
//                  busy and a 1-cycle done pulse.
module text_line_renderer
    import text_line_renderer_pkg::*;
#(
    parameter int MAX_CHARS    = 32,
    parameter int ADDR_W       = 5,
    parameter int LEN_W        = 6,
    parameter int CHAR_GAP     = 1,
    parameter int SCREEN_WIDTH = 320
) (
    input  logic                clock,
    input  logic                reset,
    text_line_renderer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_RENDER, S_RELEASE, S_ADVANCE, S_FINISH
    } state_t;

    state_t            state_q, state_d;
    y_t                oy_q, oy_d;
    sz_t               sz_q, sz_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    x_t                cur_x_q, cur_x_d;
    logic [1:0]        guard_q, guard_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    char_t             char_out_q, char_out_d;
    x_t                cox_q, cox_d;
    y_t                coy_q, coy_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    x_t               next_x;
    logic             clip;
    logic [LEN_W-1:0] len_sat;
    logic [LEN_W-1:0] idx_inc;

    text_line_renderer_glyph_advance_calc #(
        .CHAR_GAP    (CHAR_GAP),
        .SCREEN_WIDTH(SCREEN_WIDTH)
    ) u_advance (
        .sz_i    (sz_q),
        .cur_x_i (cur_x_q),
        .next_x_o(next_x),
        .clip_o  (clip)
    );

    assign len_sat = (bus.length > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : bus.length;
    assign idx_inc = idx_q + LEN_W'(1);

    always_comb begin
        state_d    = state_q;
        oy_d       = oy_q;
        sz_d       = sz_q;
        len_d      = len_q;
        idx_d      = idx_q;
        cur_x_d    = cur_x_q;
        guard_d    = guard_q;
        buf_addr_d = buf_addr_q;
        char_out_d = char_out_q;
        cox_d      = cox_q;
        coy_d      = coy_q;
        en_d       = en_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    oy_d    = bus.origin_y;
                    sz_d    = bus.size;
                    len_d   = len_sat;
                    cur_x_d = bus.origin_x;
                    idx_d   = '0;
                    state_d = (bus.length == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                buf_addr_d = idx_q[ADDR_W-1:0];
                state_d    = S_WAIT;
            end
            S_WAIT: state_d = S_CHECK;
            S_CHECK: begin
                // Terminator beats clipping, clipping beats the space skip.
                if (bus.buf_data == `CHAR_NUL || clip) begin
                    state_d = S_FINISH;
                end else if (bus.buf_data == `CHAR_SPACE) begin
                    state_d = S_ADVANCE;
                end else begin
                    char_out_d = bus.buf_data;
                    cox_d      = cur_x_q;
                    coy_d      = oy_q;
                    en_d       = 1'b1;
                    guard_d    = '0;
                    state_d    = S_RENDER;
                end
            end
            S_RENDER: begin
                if (guard_q < 2'(GUARD_CYCLES)) begin
                    guard_d = guard_q + 2'd1;
                end else if (bus.char_finished) begin
                    en_d    = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            // One full low-enable cycle lets the responder drop its finish flag.
            S_RELEASE: state_d = S_ADVANCE;
            S_ADVANCE: begin
                cur_x_d = next_x;
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? S_FINISH : S_FETCH;
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            guard_q    <= '0;
            buf_addr_q <= '0;
            char_out_q <= '0;
            cox_q      <= '0;
            coy_q      <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            guard_q    <= guard_d;
            buf_addr_q <= buf_addr_d;
            char_out_q <= char_out_d;
            cox_q      <= cox_d;
            coy_q      <= coy_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Line geometry is only consumed after a start reloads it.
    always_ff @(posedge clock) begin
        oy_q    <= oy_d;
        sz_q    <= sz_d;
        len_q   <= len_d;
        cur_x_q <= cur_x_d;
    end

    assign bus.buf_addr      = buf_addr_q;
    assign bus.char_out      = char_out_q;
    assign bus.char_origin_x = cox_q;
    assign bus.char_origin_y = coy_q;
    assign bus.char_enable   = en_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
endmodule
